// File: rtl/dac_odelay_pkg.sv
// Shared types and helpers for the DAC lane ODELAY tap sequencer.
package dac_odelay_pkg;

  localparam int TAP_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_SETTLE,
    S_VERIFY,
    S_RESP
  } state_t;

  // Bit offset of lane k inside the packed per-lane tap buses.
  function automatic int lane_slice(input int k);
    return k * TAP_W;
  endfunction

endpackage

// File: rtl/dac_odelay_ctrl_if.sv
// Register-bus command/response channel of the ODELAY sequencer.
interface dac_odelay_ctrl_if #(
  parameter int LANE_W = 4
);
  import dac_odelay_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [LANE_W-1:0] req_lane;
  logic [TAP_W-1:0]  req_value;
  logic              resp_valid;
  logic [TAP_W-1:0]  resp_value;
  logic              resp_err;

  modport master (
    output req_valid, req_wr, req_lane, req_value,
    input  req_ready, resp_valid, resp_value, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_lane, req_value,
    output req_ready, resp_valid, resp_value, resp_err
  );

endinterface

// File: rtl/dac_odelay_lane_reg.sv
// One DAC lane: the tap value presented to the output buffer and its load level.
module dac_odelay_lane_reg
  import dac_odelay_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [TAP_W-1:0] wr_value,
  input  logic             load_en,
  output logic [TAP_W-1:0] tap,
  output logic             load
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap  <= '0;
      load <= 1'b0;
    end else begin
      if (wr_en) tap <= wr_value;
      load <= load_en;
    end
  end

endmodule

// File: rtl/dac_odelay_ctrl.sv
// Serves tap read/write commands: writes a lane tap, pulses its load, then
// polls the buffer readback until it matches or the verify window expires.
module dac_odelay_ctrl
  import dac_odelay_pkg::*;
#(
  parameter int N_LANES        = 16,
  parameter int LANE_W         = 4,
  parameter int SETUP_CYCLES   = 4,
  parameter int LOAD_CYCLES    = 8,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  dac_odelay_ctrl_if.slave           bus,
  output logic [N_LANES*TAP_W-1:0]   delay_count_in,
  output logic [N_LANES-1:0]         delay_load,
  input  logic [N_LANES*TAP_W-1:0]   delay_count_out
);

  localparam int MAX_A   = (SETUP_CYCLES > LOAD_CYCLES) ? SETUP_CYCLES : LOAD_CYCLES;
  localparam int MAX_B   = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LANE_W-1:0]   lane_q;
  logic [TAP_W-1:0]    value_q;
  logic [TAP_W-1:0]    resp_value_q, resp_value_d;
  logic                resp_err_q, resp_err_d;
  logic                ready_q;
  logic                accept, req_lane_ok, wr_accept;
  logic [TAP_W-1:0]    rb_req, rb_cur;
  logic [N_LANES-1:0]  wr_en, load_en;

  assign accept      = ready_q & bus.req_valid;
  assign req_lane_ok = (int'(bus.req_lane) < N_LANES);

  // Readback of the lane being requested now and of the lane being verified.
  always_comb begin
    rb_req = '0;
    rb_cur = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (bus.req_lane == LANE_W'(k)) rb_req = delay_count_out[lane_slice(k) +: TAP_W];
      if (lane_q == LANE_W'(k))       rb_cur = delay_count_out[lane_slice(k) +: TAP_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_value_d = resp_value_q;
    resp_err_d   = resp_err_q;
    wr_accept    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (!req_lane_ok) begin
            state_d      = S_RESP;
            resp_err_d   = 1'b1;
            resp_value_d = '0;
          end else if (bus.req_wr) begin
            state_d   = S_SETUP;
            wr_accept = 1'b1;
          end else begin
            state_d      = S_RESP;
            resp_err_d   = 1'b0;
            resp_value_d = rb_req;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_LOAD: begin
        if (cnt_q == CNT_W'(LOAD_CYCLES - 1)) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_VERIFY;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      // The first compare plus TIMEOUT_CYCLES retries, then give up with the last readback.
      S_VERIFY: begin
        if (rb_cur == value_q) begin
          state_d      = S_RESP;
          resp_err_d   = 1'b0;
          resp_value_d = rb_cur;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d      = S_RESP;
          resp_err_d   = 1'b1;
          resp_value_d = rb_cur;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load flops are fed from the next state so the pulse lines up with LOAD exactly.
  always_comb begin
    wr_en   = '0;
    load_en = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (bus.req_lane == LANE_W'(k)) wr_en[k] = wr_accept;
      if (lane_q == LANE_W'(k))       load_en[k] = (state_d == S_LOAD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lane_q       <= '0;
      value_q      <= '0;
      resp_value_q <= '0;
      resp_err_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_value_q <= resp_value_d;
      resp_err_q   <= resp_err_d;
      ready_q      <= (state_d == S_IDLE);
      if (accept) begin
        lane_q  <= bus.req_lane;
        value_q <= bus.req_value;
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_value = resp_value_q;
  assign bus.resp_err   = resp_err_q;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    dac_odelay_lane_reg u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[k]),
      .wr_value (bus.req_value),
      .load_en  (load_en[k]),
      .tap      (delay_count_in[lane_slice(k) +: TAP_W]),
      .load     (delay_load[k])
    );
  end

endmodule

// File: tb/tb_dac_odelay_ctrl.sv
// Bench for dac_odelay_ctrl: timeline model of each command plus a simple
// echo/stuck model of the lane buffers' readback.
module tb_dac_odelay_ctrl;
  import dac_odelay_pkg::*;

  localparam int N       = 12;
  localparam int LW      = 4;
  localparam int TW      = 9;
  localparam int SETUP   = 4;
  localparam int LOAD    = 8;
  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 256;
  localparam int NOM_LAT = SETUP + LOAD + SETTLE + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N*TW-1:0] delay_count_in;
  logic [N-1:0]    delay_load;
  logic [N*TW-1:0] dco     = '0;
  logic [N*TW-1:0] pipe1   = '0;
  logic [N*TW-1:0] buf_tap = '0;
  bit stuck = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  dac_odelay_ctrl_if #(.LANE_W(LW)) bus ();

  dac_odelay_ctrl #(
    .N_LANES(N), .LANE_W(LW), .SETUP_CYCLES(SETUP), .LOAD_CYCLES(LOAD),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .delay_count_in  (delay_count_in),
    .delay_load      (delay_load),
    .delay_count_out (dco)
  );

  always #5 clk = ~clk;

  // Lane buffers: capture while load is high, readback two flops later (or stuck at 0).
  always @(posedge clk) begin
    for (int k = 0; k < N; k++)
      if (delay_load[k]) buf_tap[k*TW +: TW] <= delay_count_in[k*TW +: TW];
    pipe1 <= buf_tap;
    dco   <= stuck ? '0 : pipe1;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Command timeline model: m_t counts cycles since acceptance, response due at m_t == m_R.
  bit         m_ready = 1'b0, m_busy = 1'b0, m_wr = 1'b0, m_ok = 1'b0, m_rerr = 1'b0;
  int         m_t = 0, m_R = 0, m_lane = 0;
  logic [8:0] m_val = '0, m_rval = '0;
  logic [8:0] exp_tap [N];
  logic [8:0] loaded  [N];

  initial for (int k = 0; k < N; k++) loaded[k] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1'b0;
      m_busy  = 1'b0;
      m_t     = 0;
      for (int k = 0; k < N; k++) exp_tap[k] = '0;
    end else begin : mdl
      bit acc;
      acc = m_ready && bus.req_valid;
      if (m_busy) begin
        m_t++;
        if (m_t > m_R) m_busy = 1'b0;
        else if (m_wr && m_ok && m_t == SETUP + 1) loaded[m_lane] = m_val;
      end
      if (acc) begin
        m_busy = 1'b1;
        m_t    = 1;
        m_wr   = bus.req_wr;
        m_lane = int'(bus.req_lane);
        m_val  = bus.req_value;
        m_ok   = (m_lane < N);
        if (!m_ok) begin
          m_R = 1; m_rerr = 1'b1; m_rval = '0;
        end else if (!m_wr) begin
          m_R = 1; m_rerr = 1'b0; m_rval = stuck ? 9'h000 : loaded[m_lane];
        end else begin
          exp_tap[m_lane] = m_val;
          if (!stuck || m_val == 9'h000) begin
            m_R = NOM_LAT; m_rerr = 1'b0; m_rval = m_val;
          end else begin
            m_R = NOM_LAT + TIMEOUT; m_rerr = 1'b1; m_rval = '0;
          end
        end
      end
      m_ready = !m_busy;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin : cmp
      logic [N*TW-1:0] e_dci;
      logic [N-1:0]    e_dl;
      bit              e_rv;
      for (int k = 0; k < N; k++) e_dci[k*TW +: TW] = exp_tap[k];
      e_dl = '0;
      if (m_busy && m_wr && m_ok && m_t > SETUP && m_t <= SETUP + LOAD) e_dl[m_lane] = 1'b1;
      e_rv = m_busy && (m_t == m_R);
      checkOutput("req_ready", bus.req_ready, m_ready);
      checkOutput("resp_valid", bus.resp_valid, e_rv);
      checkOutput("delay_load", delay_load, e_dl);
      checkOutput("delay_count_in", delay_count_in, e_dci);
      if (e_rv) begin
        checkOutput("resp_value", bus.resp_value, m_rval);
        checkOutput("resp_err", bus.resp_err, m_rerr);
      end
    end
  end

  task automatic applyStimulus(input bit wr, input logic [3:0] lane, input logic [8:0] value,
                               input bit noise, output int lat, output logic [8:0] rv,
                               output logic re, output int lcnt, output int lfirst);
    bit got;
    lat = 0; rv = '0; re = 1'b0; lcnt = 0; lfirst = 0; got = 1'b0;
    @(posedge clk); #1;
    bus.req_wr = wr; bus.req_lane = lane; bus.req_value = value; bus.req_valid = 1'b1;
    for (int w = 0; w < 64 && !got; w++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1'b1;
    end
    if (!got) begin
      checkOutput("accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    got = 1'b0;
    for (int n = 1; n <= 600 && !got; n++) begin
      if (noise) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_wr    = 1'($urandom_range(0, 1));
        bus.req_lane  = 4'($urandom_range(0, 15));
        bus.req_value = 9'($urandom_range(0, 511));
      end
      @(negedge clk);
      if (((delay_load >> lane) & 1) != 0) begin
        lcnt++;
        if (lfirst == 0) lfirst = n;
      end
      if (bus.resp_valid) begin
        got = 1'b1; lat = n; rv = bus.resp_value; re = bus.resp_err;
        bus.req_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) checkOutput("resp_timeout", 0, 1);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, lc, lf, rcount;
    logic [8:0] rv, val;
    logic re;
    logic [N*TW-1:0] exp_vec;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_lane = '0; bus.req_value = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_dci", delay_count_in, 0);
    checkOutput("rst_load", delay_load, 0);
    checkOutput("rst_ready", bus.req_ready, 0);
    checkOutput("rst_resp_valid", bus.resp_valid, 0);
    checkOutput("rst_resp_value", bus.resp_value, 0);
    checkOutput("rst_resp_err", bus.resp_err, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", bus.req_ready, 1);

    // Echoed write to lane 3.
    applyStimulus(1'b1, 4'd3, 9'h1A5, 1'b0, lat, rv, re, lc, lf);
    checkOutput("wr3_latency", lat, 22);
    checkOutput("wr3_value", rv, 9'h1A5);
    checkOutput("wr3_err", re, 0);
    checkOutput("wr3_load_cycles", lc, 8);
    checkOutput("wr3_load_first", lf, 5);
    exp_vec = '0;
    exp_vec[3*TW +: TW] = 9'h1A5;
    checkOutput("wr3_lanes", delay_count_in, exp_vec);

    // Boundary values, with ignored requests during the busy window.
    applyStimulus(1'b1, 4'd11, 9'd511, 1'b1, lat, rv, re, lc, lf);
    checkOutput("wr11_value", rv, 9'd511);
    applyStimulus(1'b1, 4'd0, 9'd0, 1'b1, lat, rv, re, lc, lf);
    checkOutput("wr0_err", re, 0);
    applyStimulus(1'b0, 4'd11, 9'h000, 1'b0, lat, rv, re, lc, lf);
    checkOutput("rd11_latency", lat, 1);
    checkOutput("rd11_value", rv, 9'd511);
    checkOutput("rd11_err", re, 0);
    applyStimulus(1'b0, 4'd0, 9'h1FF, 1'b0, lat, rv, re, lc, lf);
    checkOutput("rd0_value", rv, 9'd0);
    checkOutput("rd0_err", re, 0);

    // Out-of-range lane.
    applyStimulus(1'b1, 4'd13, 9'h155, 1'b0, lat, rv, re, lc, lf);
    checkOutput("bad_latency", lat, 1);
    checkOutput("bad_err", re, 1);
    checkOutput("bad_value", rv, 0);

    // Readback stuck at zero forces the verify timeout.
    stuck = 1'b1;
    repeat (4) @(posedge clk);
    applyStimulus(1'b1, 4'd0, 9'h0FF, 1'b0, lat, rv, re, lc, lf);
    checkOutput("to_latency", lat, 278);
    checkOutput("to_err", re, 1);
    checkOutput("to_value", rv, 9'h000);
    stuck = 1'b0;
    repeat (4) @(posedge clk);

    // Reset during the 4th load cycle.
    @(posedge clk); #1;
    bus.req_wr = 1'b1; bus.req_lane = 4'd5; bus.req_value = 9'h0AA; bus.req_valid = 1'b1;
    rcount = 0;
    while (rcount < 64) begin
      @(negedge clk);
      if (bus.req_ready) break;
      rcount++;
    end
    if (rcount == 64) checkOutput("mid_accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_load_high", delay_load, 12'h020);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_load", delay_load, 0);
    checkOutput("mid_rst_dci", delay_count_in, 0);
    checkOutput("mid_rst_ready", bus.req_ready, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    rcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.resp_valid) rcount++;
    end
    checkOutput("mid_no_resp", rcount, 0);
    applyStimulus(1'b1, 4'd5, 9'h133, 1'b0, lat, rv, re, lc, lf);
    checkOutput("post_rst_latency", lat, 22);
    checkOutput("post_rst_value", rv, 9'h133);

    // Randomized commands against the model.
    for (int i = 0; i < 40; i++) begin
      bit st;
      st = ($urandom_range(0, 9) == 0);
      if (st != stuck) begin
        stuck = st;
        repeat (4) @(posedge clk);
      end
      case ($urandom_range(0, 5))
        0:       val = 9'd0;
        1:       val = 9'd511;
        default: val = 9'($urandom_range(0, 511));
      endcase
      applyStimulus($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), val, 1'b1,
                    lat, rv, re, lc, lf);
    end
    stuck = 1'b0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
